// File: rtl/ex_div_pkg.sv
// Shared encodings for the RV32M divide unit: operation codes, widths and FSM states.
package ex_div_pkg;

    localparam int REG_DATA = 32;
    localparam int REG_ADDR = 5;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // DIV and REM are the signed forms; op[0] marks the unsigned variants.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of a value pair; yields operand
// magnitudes on the way in and applies result signs on the way out.
module div_sign_fix
    import ex_div_pkg::*;
#(
    parameter int DATA_W = REG_DATA
) (
    input  logic [DATA_W-1:0] a,
    input  logic              neg_a,
    input  logic [DATA_W-1:0] b,
    input  logic              neg_b,
    output logic [DATA_W-1:0] a_fix,
    output logic [DATA_W-1:0] b_fix
);

    assign a_fix = neg_a ? (~a + 1'b1) : a;
    assign b_fix = neg_b ? (~b + 1'b1) : b;

endmodule

// File: rtl/ex_div.sv
// Multi-cycle RV32M divide/remainder unit: restoring division, one quotient bit
// per cycle, stalling the pipeline through hold_req_o while busy.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = REG_DATA
) (
    input  logic                clk_100MHz,
    input  logic                rst,
    input  logic                start_i,
    input  logic [1:0]          op_i,
    input  logic [DATA_W-1:0]   dividend_i,
    input  logic [DATA_W-1:0]   divisor_i,
    input  logic [REG_ADDR-1:0] rd_addr_i,
    input  logic                flush_i,
    input  logic                hold_i,
    output logic                hold_req_o,
    output logic [DATA_W-1:0]   result_o,
    output logic                result_valid_o,
    output logic [REG_ADDR-1:0] rd_addr_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [1:0]          state;
    logic                rem_sel;
    logic [REG_ADDR-1:0] rd_q;
    logic                neg_quo;
    logic                neg_rem;
    logic [DATA_W-1:0]   dvd_q;
    logic [DATA_W-1:0]   dsr_q;
    logic [DATA_W-1:0]   rem_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                in_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic                div_zero;
    logic                overflow;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign in_signed = op_is_signed(op_i);
    assign a_neg     = in_signed & dividend_i[DATA_W-1];
    assign b_neg     = in_signed & divisor_i[DATA_W-1];
    assign div_zero  = (divisor_i == '0);
    assign overflow  = in_signed
                     & (dividend_i == {1'b1, {(DATA_W-1){1'b0}}})
                     & (divisor_i == '1);

    div_sign_fix #(.DATA_W(DATA_W)) u_in_fix (
        .a     (dividend_i),
        .neg_a (a_neg),
        .b     (divisor_i),
        .neg_b (b_neg),
        .a_fix (a_mag),
        .b_fix (b_mag)
    );

    // Partial remainder is kept below the divisor, so the shifted value fits in
    // DATA_W+1 bits and the top bit of the difference is a clean borrow flag.
    assign trial = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dsr_q};

    div_sign_fix #(.DATA_W(DATA_W)) u_out_fix (
        .a     (dvd_q),
        .neg_a (neg_quo),
        .b     (rem_q),
        .neg_b (neg_rem),
        .a_fix (quo_fix),
        .b_fix (rem_fix)
    );

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state   <= ST_IDLE;
            rem_sel <= 1'b0;
            rd_q    <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else if (!hold_i) begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        rem_sel <= op_i[1];
                        rd_q    <= rd_addr_i;
                        // Special cases load final values directly, no sign fix-up.
                        if (div_zero) begin
                            dvd_q   <= '1;
                            rem_q   <= dividend_i;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= ST_DONE;
                        end else if (overflow) begin
                            dvd_q   <= dividend_i;
                            rem_q   <= '0;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            dvd_q   <= a_mag;
                            dsr_q   <= b_mag;
                            rem_q   <= '0;
                            neg_quo <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            cnt_q   <= CNT_W'(DATA_W);
                            state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    // Dividend bits shift out the top while quotient bits fill the bottom.
                    if (!trial[DATA_W]) begin
                        rem_q <= trial[DATA_W-1:0];
                        dvd_q <= {dvd_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
                        dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hold_req_o     = ((state == ST_IDLE) & start_i & ~flush_i) | (state == ST_CALC);
    assign result_valid_o = (state == ST_DONE) & ~hold_i & ~flush_i;
    assign result_o       = (state == ST_DONE) ? (rem_sel ? rem_fix : quo_fix) : '0;
    assign rd_addr_o      = rd_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed scenarios plus randomized
// back-to-back operations compared against an arithmetic reference model.
module tb_ex_div;

    logic        clk_100MHz = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        hold_req;
    logic [31:0] result;
    logic        result_valid;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    ex_div #(.DATA_W(32)) dut (
        .clk_100MHz     (clk_100MHz),
        .rst            (rst),
        .start_i        (start),
        .op_i           (op),
        .dividend_i     (dividend),
        .divisor_i      (divisor),
        .rd_addr_i      (rd_addr),
        .flush_i        (flush),
        .hold_i         (hold),
        .hold_req_o     (hold_req),
        .result_o       (result),
        .result_valid_o (result_valid),
        .rd_addr_o      (rd_out)
    );

    // RV32M semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Runs one operation starting at cycle 0 (optionally a second start), returns
    // the cycle of result_valid (-1 if none) and the hold_req trace per cycle.
    task automatic exec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold_from, input int hold_to,
                        input int flush_at, input int start2_at,
                        output int vcyc, output logic [31:0] res, output logic [4:0] rdo,
                        output logic [63:0] hq);
        vcyc = -1;
        res  = '0;
        rdo  = '0;
        hq   = '0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk_100MHz);
            #1;
            start    = (c == 0) || (c == start2_at);
            op       = o;
            dividend = a;
            divisor  = b;
            rd_addr  = rd;
            hold     = (c >= hold_from) && (c <= hold_to);
            flush    = (c == flush_at);
            #3;
            hq[c] = hold_req;
            if (result_valid) begin
                vcyc = c;
                res  = result;
                rdo  = rd_out;
                break;
            end
        end
        start = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_100MHz);
        #1;
        rst = 1'b0;
        #3;
        checks += 4;
        if (hold_req !== 1'b0) begin failures++; $display("FAIL reset_hold_req got=%b exp=0", hold_req); end
        if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        if (rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_out); end
    endtask

    task automatic test_divu_basic();
        int vc;
        logic [31:0] r;
        logic [4:0] rdo;
        logic [63:0] hq;
        exec(2'b01, 32'd100, 32'd7, 5'd5, -1, -1, -1, -1, vc, r, rdo, hq);
        checks += 4;
        if (vc != 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", vc); end
        if (r !== 32'd14) begin failures++; $display("FAIL divu_result got=%0d exp=14", r); end
        if (rdo !== 5'd5) begin failures++; $display("FAIL divu_rd got=%0d exp=5", rdo); end
        if (hq[33:0] !== {1'b0, {33{1'b1}}}) begin failures++; $display("FAIL divu_hold_req got=%h exp=%h", hq[33:0], {1'b0, {33{1'b1}}}); end
        exec(2'b11, 32'd100, 32'd7, 5'd6, -1, -1, -1, -1, vc, r, rdo, hq);
        checks += 2;
        if (vc != 33) begin failures++; $display("FAIL remu_latency got=%0d exp=33", vc); end
        if (r !== 32'd2) begin failures++; $display("FAIL remu_result got=%0d exp=2", r); end
    endtask

    task automatic test_signed();
        logic [1:0]  ops [3] = '{2'b00, 2'b10, 2'b10};
        logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
        logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
        int vc;
        logic [31:0] r;
        logic [4:0] rdo;
        logic [63:0] hq;
        for (int i = 0; i < 3; i++) begin
            exec(ops[i], as[i], bs[i], 5'd9, -1, -1, -1, -1, vc, r, rdo, hq);
            checks += 2;
            if (vc != 33) begin failures++; $display("FAIL signed_latency[%0d] got=%0d exp=33", i, vc); end
            if (r !== exp[i]) begin failures++; $display("FAIL signed_result[%0d] got=%h exp=%h", i, r, exp[i]); end
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [4] = '{2'b00, 2'b11, 2'b00, 2'b10};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int vc;
        logic [31:0] r;
        logic [4:0] rdo;
        logic [63:0] hq;
        for (int i = 0; i < 4; i++) begin
            exec(ops[i], as[i], bs[i], 5'(i + 1), -1, -1, -1, -1, vc, r, rdo, hq);
            checks += 4;
            if (vc != 1) begin failures++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, vc); end
            if (r !== exp[i]) begin failures++; $display("FAIL special_result[%0d] got=%h exp=%h", i, r, exp[i]); end
            if (rdo !== 5'(i + 1)) begin failures++; $display("FAIL special_rd[%0d] got=%0d exp=%0d", i, rdo, i + 1); end
            if (hq[1:0] !== 2'b01) begin failures++; $display("FAIL special_hold_req[%0d] got=%b exp=01", i, hq[1:0]); end
        end
    endtask

    task automatic test_flush();
        int vc;
        logic [31:0] r;
        logic [4:0] rdo;
        logic [63:0] hq;
        exec(2'b01, 32'd100, 32'd7, 5'd3, -1, -1, 10, -1, vc, r, rdo, hq);
        checks += 3;
        if (vc != -1) begin failures++; $display("FAIL flush_no_valid got=%0d exp=-1", vc); end
        if (hq[10] !== 1'b1) begin failures++; $display("FAIL flush_hold_req_c10 got=%b exp=1", hq[10]); end
        if (hq[20:11] !== 10'd0) begin failures++; $display("FAIL flush_hold_req_low got=%h exp=0", hq[20:11]); end
        exec(2'b01, 32'd100, 32'd7, 5'd4, -1, -1, 10, 11, vc, r, rdo, hq);
        checks += 3;
        if (vc != 44) begin failures++; $display("FAIL flush_restart_latency got=%0d exp=44", vc); end
        if (r !== 32'd14) begin failures++; $display("FAIL flush_restart_result got=%0d exp=14", r); end
        if (hq[44:11] !== {1'b0, {33{1'b1}}}) begin failures++; $display("FAIL flush_restart_hold_req got=%h", hq[44:11]); end
    endtask

    task automatic test_hold();
        int vc;
        logic [31:0] r;
        logic [4:0] rdo;
        logic [63:0] hq;
        exec(2'b01, 32'd100, 32'd7, 5'd12, 5, 9, -1, -1, vc, r, rdo, hq);
        checks += 3;
        if (vc != 38) begin failures++; $display("FAIL hold_latency got=%0d exp=38", vc); end
        if (r !== 32'd14) begin failures++; $display("FAIL hold_result got=%0d exp=14", r); end
        if (hq[38:0] !== {1'b0, {38{1'b1}}}) begin failures++; $display("FAIL hold_hold_req got=%h", hq[38:0]); end
        // Hold during DONE delays the valid pulse by one cycle.
        exec(2'b11, 32'd100, 32'd7, 5'd13, 33, 33, -1, -1, vc, r, rdo, hq);
        checks += 2;
        if (vc != 34) begin failures++; $display("FAIL hold_done_latency got=%0d exp=34", vc); end
        if (r !== 32'd2) begin failures++; $display("FAIL hold_done_result got=%0d exp=2", r); end
    endtask

    task automatic test_rst_mid();
        int seen = 0;
        int vc;
        logic [31:0] r;
        logic [4:0] rdo;
        logic [63:0] hq;
        for (int c = 0; c <= 21; c++) begin
            @(posedge clk_100MHz);
            #1;
            start    = (c == 0);
            op       = 2'b01;
            dividend = 32'd100;
            divisor  = 32'd7;
            rd_addr  = 5'd17;
            rst      = (c == 20);
            #3;
            if (result_valid) seen++;
            if (c == 21) begin
                checks += 5;
                if (seen != 0) begin failures++; $display("FAIL rstmid_valid_seen got=%0d exp=0", seen); end
                if (hold_req !== 1'b0) begin failures++; $display("FAIL rstmid_hold_req got=%b exp=0", hold_req); end
                if (result !== 32'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", result); end
                if (rd_out !== 5'd0) begin failures++; $display("FAIL rstmid_rd got=%0d exp=0", rd_out); end
                if (result_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", result_valid); end
            end
        end
        exec(2'b01, 32'd200, 32'd9, 5'd2, -1, -1, -1, -1, vc, r, rdo, hq);
        checks += 2;
        if (vc != 33) begin failures++; $display("FAIL rstmid_after_latency got=%0d exp=33", vc); end
        if (r !== 32'd22) begin failures++; $display("FAIL rstmid_after_result got=%0d exp=22", r); end
    endtask

    task automatic test_back_to_back();
        int vc;
        logic [31:0] r;
        logic [4:0] rdo;
        logic [63:0] hq;
        logic [1:0] o;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0] rd;
        int kind;
        for (int i = 0; i < 30; i++) begin
            o    = 2'($urandom_range(0, 3));
            a    = $urandom;
            b    = $urandom;
            rd   = 5'($urandom_range(0, 31));
            kind = $urandom_range(0, 7);
            if (kind == 0) b = 32'd0;
            else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (kind == 2) b = 32'($urandom_range(1, 20));
            else if (kind == 3) b = -32'($urandom_range(1, 20));
            exec(o, a, b, rd, -1, -1, -1, -1, vc, r, rdo, hq);
            checks += 3;
            if (vc != ref_latency(o, a, b)) begin failures++; $display("FAIL rand_latency[%0d] op=%0d a=%h b=%h got=%0d exp=%0d", i, o, a, b, vc, ref_latency(o, a, b)); end
            if (r !== ref_result(o, a, b)) begin failures++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, r, ref_result(o, a, b)); end
            if (rdo !== rd) begin failures++; $display("FAIL rand_rd[%0d] got=%0d exp=%0d", i, rdo, rd); end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_special();
        test_flush();
        test_hold();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
